// File: rtl/ddr2_arbiter_pkg.sv
// rtl/ddr2_arbiter_pkg.sv - shared widths, one-hot states and DDR2 command constants for ddr2_arbiter
package ddr2_arbiter_pkg;

    localparam int DDR2_BA_BITS   = 3;
    localparam int DDR2_ADDR_BITS = 13;

    typedef enum logic [4:0] {
        ST_INIT  = 5'b00001,
        ST_IDLE  = 5'b00010,
        ST_AREF  = 5'b00100,
        ST_WRITE = 5'b01000,
        ST_READ  = 5'b10000
    } arb_state_t;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_DESEL = 4'b1111;

endpackage

// File: rtl/ddr2_arb_rr.sv
// rtl/ddr2_arb_rr.sv - 2-way write/read round-robin picker; pick[0]=write, pick[1]=read
module ddr2_arb_rr (
    input  logic       wr_req,
    input  logic       rd_req,
    input  logic       lrr_wr,
    output logic [1:0] pick
);

    always_comb begin
        pick = 2'b00;
        if (wr_req && rd_req) begin
            // on a tie, favour the type that was not granted last
            pick = lrr_wr ? 2'b10 : 2'b01;
        end else if (wr_req) begin
            pick = 2'b01;
        end else if (rd_req) begin
            pick = 2'b10;
        end
    end

endmodule

// File: rtl/ddr2_arbiter.sv
// rtl/ddr2_arbiter.sv - DDR2 init/refresh/write/read arbiter; optional watchdog via ARB_WATCHDOG_EN
module ddr2_arbiter
    import ddr2_arbiter_pkg::*;
#(
    parameter int BA_BITS   = DDR2_BA_BITS,
    parameter int ADDR_BITS = DDR2_ADDR_BITS
) (
    input  logic                 ck,
    input  logic                 rst,
    input  logic                 init_end,
    input  logic [3:0]           init_cmd,
    input  logic [3:0]           aref_cmd,
    input  logic [3:0]           wr_cmd,
    input  logic [3:0]           rd_cmd,
    input  logic [BA_BITS-1:0]   init_ba,
    input  logic [BA_BITS-1:0]   wr_ba,
    input  logic [BA_BITS-1:0]   rd_ba,
    input  logic [ADDR_BITS-1:0] init_addr,
    input  logic [ADDR_BITS-1:0] aref_addr,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [ADDR_BITS-1:0] rd_addr,
    input  logic                 aref_req,
    input  logic                 wr_req,
    input  logic                 rd_req,
    input  logic                 aref_end,
    input  logic                 wr_end,
    input  logic                 rd_end,
    output logic                 aref_en,
    output logic                 wr_en,
    output logic                 rd_en,
    output logic                 ddr2_cs_n,
    output logic                 ddr2_ras_n,
    output logic                 ddr2_cas_n,
    output logic                 ddr2_we_n,
    output logic [BA_BITS-1:0]   ddr2_ba,
    output logic [ADDR_BITS-1:0] ddr2_addr,
    output logic [4:0]           arb_state,
    output logic                 arb_err
);

    arb_state_t state_q, state_d;
    logic       aref_en_d, wr_en_d, rd_en_d;
    logic       aref_pend, lrr_wr;
    logic [1:0] pick;
    logic [3:0] cmd_q;
    logic       op_state;
    logic       wd_trip;

    assign op_state = (state_q == ST_AREF) || (state_q == ST_WRITE) || (state_q == ST_READ);

    ddr2_arb_rr u_rr (
        .wr_req (wr_req),
        .rd_req (rd_req),
        .lrr_wr (lrr_wr),
        .pick   (pick)
    );

`ifdef ARB_WATCHDOG_EN
    logic [9:0] wd_cnt;

    assign wd_trip = op_state && (wd_cnt == 10'd1023);

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            arb_err <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                wd_cnt <= '0;
            end else if (op_state) begin
                wd_cnt <= wd_cnt + 10'd1;
            end
            if (wd_trip) begin
                arb_err <= 1'b1;
            end
        end
    end
`else
    assign wd_trip = 1'b0;
    assign arb_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        aref_en_d = 1'b0;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        case (state_q)
            ST_INIT:  if (init_end) state_d = ST_IDLE;
            ST_IDLE: begin
                if (aref_pend || aref_req) begin
                    state_d   = ST_AREF;
                    aref_en_d = 1'b1;
                end else if (pick[0]) begin
                    state_d = ST_WRITE;
                    wr_en_d = 1'b1;
                end else if (pick[1]) begin
                    state_d = ST_READ;
                    rd_en_d = 1'b1;
                end
            end
            ST_AREF:  if (wd_trip || aref_end) state_d = ST_IDLE;
            ST_WRITE: if (wd_trip || wr_end)   state_d = ST_IDLE;
            ST_READ:  if (wd_trip || rd_end)   state_d = ST_IDLE;
            default:  state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INIT;
            aref_en   <= 1'b0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            aref_pend <= 1'b0;
            lrr_wr    <= 1'b0;
        end else begin
            state_q <= state_d;
            aref_en <= aref_en_d;
            wr_en   <= wr_en_d;
            rd_en   <= rd_en_d;
            // a refresh asked for while busy must not be lost
            if (aref_en_d) begin
                aref_pend <= 1'b0;
            end else if (aref_req && (state_q != ST_IDLE)) begin
                aref_pend <= 1'b1;
            end
            if (wr_en_d) begin
                lrr_wr <= 1'b1;
            end else if (rd_en_d) begin
                lrr_wr <= 1'b0;
            end
        end
    end

    // command bus trails the state register by one cycle
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            cmd_q     <= CMD_DESEL;
            ddr2_ba   <= '0;
            ddr2_addr <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cmd_q     <= init_cmd;
                    ddr2_ba   <= init_ba;
                    ddr2_addr <= init_addr;
                end
                ST_IDLE:  cmd_q <= CMD_NOP;
                ST_AREF: begin
                    cmd_q     <= aref_cmd;
                    ddr2_ba   <= '0;
                    ddr2_addr <= aref_addr;
                end
                ST_WRITE: begin
                    cmd_q     <= wr_cmd;
                    ddr2_ba   <= wr_ba;
                    ddr2_addr <= wr_addr;
                end
                ST_READ: begin
                    cmd_q     <= rd_cmd;
                    ddr2_ba   <= rd_ba;
                    ddr2_addr <= rd_addr;
                end
                default:  cmd_q <= CMD_DESEL;
            endcase
        end
    end

    assign {ddr2_cs_n, ddr2_ras_n, ddr2_cas_n, ddr2_we_n} = cmd_q;
    assign arb_state = state_q;

endmodule

// File: tb/tb_ddr2_arbiter.sv
// tb/tb_ddr2_arbiter.sv - directed self-checking bench for ddr2_arbiter
module tb_ddr2_arbiter;

    localparam logic [4:0] S_INIT  = 5'b00001;
    localparam logic [4:0] S_IDLE  = 5'b00010;
    localparam logic [4:0] S_AREF  = 5'b00100;
    localparam logic [4:0] S_WRITE = 5'b01000;
    localparam logic [4:0] S_READ  = 5'b10000;

    localparam logic [3:0]  AREF_CMD  = 4'b0001;
    localparam logic [12:0] AREF_ADDR = 13'h0400;
    localparam logic [3:0]  WR_CMD    = 4'b0100;
    localparam logic [2:0]  WR_BA     = 3'd2;
    localparam logic [12:0] WR_ADDR   = 13'h00AB;
    localparam logic [3:0]  RD_CMD    = 4'b0101;
    localparam logic [2:0]  RD_BA     = 3'd6;
    localparam logic [12:0] RD_ADDR   = 13'h01CD;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic        init_end = 1'b0;
    logic [3:0]  init_cmd = 4'b1111;
    logic [3:0]  aref_cmd = AREF_CMD;
    logic [3:0]  wr_cmd = WR_CMD;
    logic [3:0]  rd_cmd = RD_CMD;
    logic [2:0]  init_ba = 3'd0;
    logic [2:0]  wr_ba = WR_BA;
    logic [2:0]  rd_ba = RD_BA;
    logic [12:0] init_addr = 13'h0;
    logic [12:0] aref_addr = AREF_ADDR;
    logic [12:0] wr_addr = WR_ADDR;
    logic [12:0] rd_addr = RD_ADDR;
    logic        aref_req = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
    logic        aref_end = 1'b0, wr_end = 1'b0, rd_end = 1'b0;
    logic        aref_en, wr_en, rd_en;
    logic        ddr2_cs_n, ddr2_ras_n, ddr2_cas_n, ddr2_we_n;
    logic [2:0]  ddr2_ba;
    logic [12:0] ddr2_addr;
    logic [4:0]  arb_state;
    logic        arb_err;
    logic [3:0]  cmd;

    int n_cmp = 0;
    int n_bad = 0;

    assign cmd = {ddr2_cs_n, ddr2_ras_n, ddr2_cas_n, ddr2_we_n};

    always #5 ck = ~ck;

    ddr2_arbiter dut (
        .ck(ck), .rst(rst), .init_end(init_end),
        .init_cmd(init_cmd), .aref_cmd(aref_cmd), .wr_cmd(wr_cmd), .rd_cmd(rd_cmd),
        .init_ba(init_ba), .wr_ba(wr_ba), .rd_ba(rd_ba),
        .init_addr(init_addr), .aref_addr(aref_addr), .wr_addr(wr_addr), .rd_addr(rd_addr),
        .aref_req(aref_req), .wr_req(wr_req), .rd_req(rd_req),
        .aref_end(aref_end), .wr_end(wr_end), .rd_end(rd_end),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
        .ddr2_cs_n(ddr2_cs_n), .ddr2_ras_n(ddr2_ras_n), .ddr2_cas_n(ddr2_cas_n), .ddr2_we_n(ddr2_we_n),
        .ddr2_ba(ddr2_ba), .ddr2_addr(ddr2_addr), .arb_state(arb_state), .arb_err(arb_err)
    );

    task automatic step();
        @(posedge ck);
        @(negedge ck);
    endtask

    task automatic reset_to_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        init_end = 1'b1;
        step();
    endtask

    task automatic test_reset();
        step();
        n_cmp++;
        if ({arb_state, aref_en, wr_en, rd_en, cmd, ddr2_ba, ddr2_addr, arb_err} !==
            {S_INIT, 3'b000, 4'b1111, 3'd0, 13'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_values: state=%b en=%b%b%b cmd=%b ba=%0d addr=%h err=%b, need 00001 000 1111 0 0 0",
                     arb_state, aref_en, wr_en, rd_en, cmd, ddr2_ba, ddr2_addr, arb_err);
        end
    endtask

    task automatic test_init();
        logic [3:0] exp_cmd;
        init_ba   = 3'd5;
        init_addr = 13'h0123;
        rst = 1'b0;
        wr_req = 1'b1;
        for (int i = 0; i < 200; i++) begin
            exp_cmd  = 4'(i * 7);
            init_cmd = exp_cmd;
            step();
            n_cmp++;
            if (arb_state !== S_INIT || cmd !== exp_cmd || wr_en !== 1'b0) begin
                n_bad++;
                $display("FAIL init_hold[%0d]: state=%b cmd=%b wr_en=%b, need 00001 %b 0", i, arb_state, cmd, wr_en, exp_cmd);
            end
        end
        wr_req = 1'b0;
        init_end = 1'b1;
        step();
        n_cmp++;
        if (arb_state !== S_IDLE) begin
            n_bad++;
            $display("FAIL init_to_idle: state=%b, need 00010", arb_state);
        end
        step();
        n_cmp++;
        if (cmd !== 4'b0111 || ddr2_ba !== 3'd5 || ddr2_addr !== 13'h0123) begin
            n_bad++;
            $display("FAIL idle_nop: cmd=%b ba=%0d addr=%h, need 0111 5 0123", cmd, ddr2_ba, ddr2_addr);
        end
    endtask

    task automatic test_aref_priority();
        aref_req = 1'b1;
        wr_req   = 1'b1;
        step();
        aref_req = 1'b0;
        n_cmp++;
        if (arb_state !== S_AREF || aref_en !== 1'b1 || wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL aref_first: state=%b aref_en=%b wr_en=%b, need 00100 1 0", arb_state, aref_en, wr_en);
        end
        step();
        n_cmp++;
        if (aref_en !== 1'b0 || cmd !== AREF_CMD || ddr2_ba !== 3'd0 || ddr2_addr !== AREF_ADDR) begin
            n_bad++;
            $display("FAIL aref_bus: aref_en=%b cmd=%b ba=%0d addr=%h, need 0 %b 0 %h",
                     aref_en, cmd, ddr2_ba, ddr2_addr, AREF_CMD, AREF_ADDR);
        end
        aref_end = 1'b1;
        step();
        aref_end = 1'b0;
        n_cmp++;
        if (arb_state !== S_IDLE || wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL aref_return: state=%b wr_en=%b, need 00010 0", arb_state, wr_en);
        end
        step();
        wr_req = 1'b0;
        n_cmp++;
        if (arb_state !== S_WRITE || wr_en !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_after_aref: state=%b wr_en=%b, need 01000 1", arb_state, wr_en);
        end
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] order;
        int         n = 0;
        int         cd = 0;
        logic       last_w = 1'b0;
        reset_to_idle();
        order  = 4'b0000;
        wr_req = 1'b1;
        rd_req = 1'b1;
        for (int cyc = 0; cyc < 200 && n < 4; cyc++) begin
            step();
            wr_end = 1'b0;
            rd_end = 1'b0;
            if (wr_en || rd_en) begin
                order[3-n] = wr_en;
                last_w = wr_en;
                n++;
                cd = 3;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    if (last_w) wr_end = 1'b1;
                    else        rd_end = 1'b1;
                end
            end
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        n_cmp++;
        if (n != 4 || order !== 4'b1010) begin
            n_bad++;
            $display("FAIL rr_order: grants=%0d order(1=W)=%b, need 4 1010", n, order);
        end
        if (last_w) wr_end = 1'b1;
        else        rd_end = 1'b1;
        step();
        wr_end = 1'b0;
        rd_end = 1'b0;
        n_cmp++;
        if (arb_state !== S_IDLE) begin
            n_bad++;
            $display("FAIL rr_finish: state=%b, need 00010", arb_state);
        end
    endtask

    task automatic test_aref_pending();
        wr_req = 1'b1;
        step();
        wr_req = 1'b0;
        rd_req = 1'b1;
        step();
        n_cmp++;
        if (arb_state !== S_WRITE || cmd !== WR_CMD || ddr2_ba !== WR_BA || ddr2_addr !== WR_ADDR) begin
            n_bad++;
            $display("FAIL write_bus: state=%b cmd=%b ba=%0d addr=%h, need 01000 %b %0d %h",
                     arb_state, cmd, ddr2_ba, ddr2_addr, WR_CMD, WR_BA, WR_ADDR);
        end
        aref_req = 1'b1;
        rd_end   = 1'b1;
        step();
        aref_req = 1'b0;
        rd_end   = 1'b0;
        step();
        n_cmp++;
        if (arb_state !== S_WRITE) begin
            n_bad++;
            $display("FAIL foreign_end: state=%b, need 01000", arb_state);
        end
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        n_cmp++;
        if (arb_state !== S_IDLE || rd_en !== 1'b0 || aref_en !== 1'b0) begin
            n_bad++;
            $display("FAIL pend_idle: state=%b rd_en=%b aref_en=%b, need 00010 0 0", arb_state, rd_en, aref_en);
        end
        step();
        n_cmp++;
        if (arb_state !== S_AREF || aref_en !== 1'b1 || rd_en !== 1'b0) begin
            n_bad++;
            $display("FAIL pend_aref: state=%b aref_en=%b rd_en=%b, need 00100 1 0", arb_state, aref_en, rd_en);
        end
        step();
        aref_end = 1'b1;
        step();
        aref_end = 1'b0;
        step();
        rd_req = 1'b0;
        n_cmp++;
        if (arb_state !== S_READ || rd_en !== 1'b1) begin
            n_bad++;
            $display("FAIL read_after_pend: state=%b rd_en=%b, need 10000 1", arb_state, rd_en);
        end
    endtask

    task automatic test_reset_in_read();
        step();
        n_cmp++;
        if (cmd !== RD_CMD || ddr2_ba !== RD_BA || ddr2_addr !== RD_ADDR) begin
            n_bad++;
            $display("FAIL read_bus: cmd=%b ba=%0d addr=%h, need %b %0d %h", cmd, ddr2_ba, ddr2_addr, RD_CMD, RD_BA, RD_ADDR);
        end
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({arb_state, aref_en, wr_en, rd_en, cmd, ddr2_ba, ddr2_addr} !== {S_INIT, 3'b000, 4'b1111, 3'd0, 13'd0}) begin
            n_bad++;
            $display("FAIL async_reset: state=%b en=%b%b%b cmd=%b ba=%0d addr=%h, need 00001 000 1111 0 0",
                     arb_state, aref_en, wr_en, rd_en, cmd, ddr2_ba, ddr2_addr);
        end
        step();
        rst = 1'b0;
        step();
        n_cmp++;
        if (arb_state !== S_IDLE || rd_en !== 1'b0) begin
            n_bad++;
            $display("FAIL after_abort: state=%b rd_en=%b, need 00010 0", arb_state, rd_en);
        end
    endtask

    task automatic test_watchdog();
        int k = 0;
        wr_req = 1'b1;
        step();
        wr_req = 1'b0;
`ifdef ARB_WATCHDOG_EN
        while (k < 1100 && arb_state !== S_IDLE) begin
            step();
            k++;
        end
        n_cmp++;
        if (k != 1024 || arb_err !== 1'b1) begin
            n_bad++;
            $display("FAIL watchdog_trip: cycles=%0d err=%b, need 1024 1", k, arb_err);
        end
        for (int i = 0; i < 20; i++) step();
        n_cmp++;
        if (arb_err !== 1'b1) begin
            n_bad++;
            $display("FAIL watchdog_sticky: err=%b, need 1", arb_err);
        end
        reset_to_idle();
        n_cmp++;
        if (arb_err !== 1'b0) begin
            n_bad++;
            $display("FAIL watchdog_clear: err=%b, need 0", arb_err);
        end
`else
        for (k = 0; k < 1100; k++) step();
        n_cmp++;
        if (arb_state !== S_WRITE || arb_err !== 1'b0) begin
            n_bad++;
            $display("FAIL no_watchdog: state=%b err=%b, need 01000 0", arb_state, arb_err);
        end
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_init();
        test_aref_priority();
        test_round_robin();
        test_aref_pending();
        test_reset_in_read();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ddr2_arbiter.md
DDR2_ARBITER -- requirements
Module: ddr2_arbiter

Interface
REQ-001 Parameter: BA_BITS, 3, DDR2 bank address width.
REQ-002 Parameter: ADDR_BITS, 13, DDR2 row/column address width.
REQ-003 Port: ck  in  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: init_end  in  1  initialisation complete; level, held high once asserted.
REQ-006 Ports: init_cmd, aref_cmd, wr_cmd, rd_cmd  in  4 each  requester command {cs_n,ras_n,cas_n,we_n}.
REQ-007 Ports: init_ba, wr_ba, rd_ba  in  BA_BITS each  requester bank address.
REQ-008 Ports: init_addr, aref_addr, wr_addr, rd_addr  in  ADDR_BITS each  requester address.
REQ-009 Ports: aref_req, wr_req, rd_req  in  1 each  level request.
REQ-010 Ports: aref_end, wr_end, rd_end  in  1 each  one-cycle pulse; the granted operation is finished.
REQ-011 Ports: aref_en, wr_en, rd_en  out  1 each  one-cycle grant pulse.
REQ-012 Ports: ddr2_cs_n, ddr2_ras_n, ddr2_cas_n, ddr2_we_n  out  1 each  registered command bus.
REQ-013 Ports: ddr2_ba  out  BA_BITS and ddr2_addr  out  ADDR_BITS  registered address bus.
REQ-014 Port: arb_state  out  5  current one-hot state.
REQ-015 Port: arb_err  out  1  sticky watchdog error (see Configuration).

Function
REQ-016 States (one-hot): INIT=00001, IDLE=00010, AREF=00100, WRITE=01000, READ=10000.
REQ-017 Transitions: INIT->IDLE on init_end; AREF->IDLE on aref_end; WRITE->IDLE on wr_end; READ->IDLE on rd_end; otherwise hold; an illegal encoding goes to INIT.
REQ-018 IDLE priority, sampled at edge N: pending refresh first, then write/read; the target state and the matching en pulse are both registered at edge N, so en is high for exactly cycle N..N+1.
REQ-019 Write versus read: when both are requesting, grant the type not granted last; lrr_wr resets to 0, so write wins the first tie.
REQ-020 Refresh pending: an aref_req seen in any state other than IDLE sets aref_pend; aref_pend clears when aref_en issues; aref_pend beats wr_req/rd_req on the next IDLE.
REQ-021 No grant on the edge that returns to IDLE; at least one IDLE cycle separates operations.
REQ-022 Command mux, registered, one cycle after the state: INIT -> init_*; AREF -> aref_cmd/aref_addr with ba=0; WRITE -> wr_*; READ -> rd_*; IDLE -> NOP 0111, with ba/addr holding their last value.
REQ-023 An end pulse arriving in a state it does not belong to is ignored.
REQ-024 No request is granted before init_end; requests raised during INIT are served in priority order once IDLE is reached.

Reset
REQ-025 While rst is high: state=INIT; aref_en, wr_en and rd_en are 0; cmd bus=1111; ddr2_ba=0; ddr2_addr=0; aref_pend=0; lrr_wr=0; arb_err=0; watchdog counter=0.
REQ-026 rst asserted mid-operation aborts the operation immediately; no end pulse is required.

Configuration
REQ-027 Macro ARB_WATCHDOG_EN is defined: a 10-bit counter clears on each state change and counts every cycle spent in AREF, WRITE or READ.
REQ-028 With ARB_WATCHDOG_EN, on reaching 1023 the state is forced to IDLE on the next edge and arb_err is set; arb_err clears only on reset.
REQ-029 Macro ARB_WATCHDOG_EN undefined: no counter exists, arb_err is tied to 0, and an operation may last indefinitely.

Structure
REQ-030 Shared package/define file holds BA_BITS, ADDR_BITS, the five state encodings, and the command constants NOP=0111 and DESEL=1111.
REQ-031 Sub-module ddr2_arb_rr is a 2-way round-robin picker (wr/rd requests and lrr_wr in, one-hot pick out); the rest of the logic is flat.

Verification
REQ-032 Reset release with init_end low for 200 cycles: state=INIT and the cmd bus follows init_cmd at +1 cycle; with init_end high, state is IDLE next cycle and the cmd bus is 0111.
REQ-033 In IDLE, aref_req=wr_req=1 at the same edge: aref_en pulses once and state=AREF; after aref_end, one IDLE cycle, then wr_en.
REQ-034 wr_req and rd_req held high continuously, with end pulsed 4 cycles after each grant: the grant order is W,R,W,R.
REQ-035 aref_req pulsed during WRITE: it is latched; after wr_end, aref_en comes before any rd_en even though rd_req is high.
REQ-036 rst asserted in READ at cycle 5: outputs take their reset values in the same cycle, state=INIT, and there is no stray rd_en.
REQ-037 ARB_WATCHDOG_EN defined and wr_end never asserted: state returns to IDLE 1024 cycles after the grant, arb_err=1, and it stays 1 until reset.
